wb_unit: RTL

Writeback stage of the RISC-V core and the sole driver of the register file write port (rd, rd_data, rd_valid). It merges single-cycle ALU results with multi-cycle load results buffered in a small load queue, and issues at most one registered write per cycle. It also keeps a pending-write scoreboard that decode uses to stall on read-after-write hazards.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_lq.sv | 47 ++++
 rtl/wb_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: widths, register count and the
// {rd, data} entry carried through the load queue.
package wb_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lq.sv
// Load queue: synchronous FIFO with circular pointers carrying a wrap bit.
// Push into a full queue and pop from an empty one are ignored.
module wb_lq #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: merges ALU and queued load results into one registered
// register-file write per cycle and tracks pending writes for hazard stalls.
// Optional WB_PERF_EN adds stall and queue-full cycle counters.
//
// Handshakes (alu_*, ld_*): a transfer occurs on a rising edge where valid and
// ready are both high; the source holds its payload stable while valid && !ready.
module wb_unit #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_valid,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            stall,
  output logic [31:0]     busy
`ifdef WB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_lqfull_cnt
`endif
);

  import wb_pkg::*;

  wb_entry_t             w_lq_head;
  wb_entry_t             w_push_entry;
  wb_entry_t             w_sel;
  logic                  w_sel_valid;
  logic                  w_lq_full;
  logic                  w_lq_empty;
  logic                  w_lq_push;
  logic                  w_lq_pop;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   r_busy;
  logic [REG_IDX_W-1:0]  r_rd;
  logic [XLEN-1:0]       r_rd_data;
  logic                  r_rd_valid;

  assign w_push_entry = '{rd: ld_rd, data: ld_data};
  assign ld_ready     = !w_lq_full;
  // x0 loads are acknowledged but never occupy a slot.
  assign w_lq_push    = ld_valid && !w_lq_full && (ld_rd != '0);
  assign alu_ready    = !w_lq_full;

  wb_lq #(
    .DEPTH (LQ_DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_lq (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_lq_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_lq_pop),
    .o_head      (w_lq_head),
    .o_full      (w_lq_full),
    .o_empty     (w_lq_empty)
  );

  always_comb begin
    w_lq_pop    = 1'b0;
    w_sel       = w_lq_head;
    w_sel_valid = 1'b0;
    if (w_lq_full) begin
      w_lq_pop    = 1'b1;
      w_sel_valid = 1'b1;
    end else if (alu_valid) begin
      w_sel       = '{rd: alu_rd, data: alu_data};
      w_sel_valid = (alu_rd != '0);
    end else if (!w_lq_empty) begin
      w_lq_pop    = 1'b1;
      w_sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_rd      <= w_sel.rd;
        r_rd_data <= w_sel.data;
      end
    end
  end

  // Clear follows the register file capturing the write; a same-edge issue wins.
  assign w_set = issue_valid ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << issue_rd) : '0;
  assign w_clr = r_rd_valid  ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << r_rd)     : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= ((r_busy & ~w_clr) | w_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
  end

  assign stall    = ((chk_rs1 != '0) && r_busy[chk_rs1]) ||
                    ((chk_rs2 != '0) && r_busy[chk_rs2]);
  assign busy     = r_busy;
  assign rd       = r_rd;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

`ifdef WB_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_lqfull_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall_cnt  <= '0;
      r_perf_lqfull_cnt <= '0;
    end else begin
      if (stall)     r_perf_stall_cnt  <= r_perf_stall_cnt + 1'b1;
      if (w_lq_full) r_perf_lqfull_cnt <= r_perf_lqfull_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt  = r_perf_stall_cnt;
  assign perf_lqfull_cnt = r_perf_lqfull_cnt;
`endif

endmodule
